// File: rtl/pipe_stage_reg_pkg.sv
// Shared CPU definitions: exception codes, instruction field positions and
// the per-edge action selected by a pipeline stage register.
package cpu_pkg;

  localparam int          CPU_EXC_W      = 5;
  localparam logic [31:0] CPU_HANDLER_PC = 32'h0000_4180;

  // MIPS Cause.ExcCode values; zero means the slot carries no exception
  localparam logic [CPU_EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [CPU_EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [CPU_EXC_W-1:0] EXC_ADES = 5'd5;
  localparam logic [CPU_EXC_W-1:0] EXC_SYS  = 5'd8;
  localparam logic [CPU_EXC_W-1:0] EXC_BP   = 5'd9;
  localparam logic [CPU_EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [CPU_EXC_W-1:0] EXC_OV   = 5'd12;

  // Instruction word field positions
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int IMM_MSB   = 15;
  localparam int INDEX_MSB = 25;

  // What the stage does on a given edge (reset is handled separately)
  typedef enum logic [2:0] {
    ACT_LOAD,
    ACT_BUBBLE,
    ACT_STALL,
    ACT_FLUSH,
    ACT_REQ
  } action_e;

  // Resolve simultaneous controls: req > flush > stall > bubble > load
  function automatic action_e decode_action(input logic req, input logic flush,
                                            input logic stall, input logic bubble);
    if (req)    return ACT_REQ;
    if (flush)  return ACT_FLUSH;
    if (stall)  return ACT_STALL;
    if (bubble) return ACT_BUBBLE;
    return ACT_LOAD;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Bundle of control, upstream slot and registered slot signals of one
// pipeline stage register. master drives the upstream side, slave is the stage.
interface pipe_stage_if #(
  parameter int DATA_W = 32,
  parameter int EXC_W  = 5,
  parameter int CNT_W  = 16
);
  logic              req;
  logic              flush;
  logic              stall;
  logic              bubble;
  logic              in_valid;
  logic [31:0]       in_pc;
  logic [31:0]       in_instr;
  logic [EXC_W-1:0]  in_exc;
  logic              in_bd;
  logic [DATA_W-1:0] in_data;

  logic              valid_q;
  logic [31:0]       pc_q;
  logic [31:0]       instr_q;
  logic [EXC_W-1:0]  exc_q;
  logic              bd_q;
  logic [DATA_W-1:0] data_q;
  logic [4:0]        rs_q;
  logic [4:0]        rt_q;
  logic [15:0]       imm16_q;
  logic [25:0]       index26_q;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output req, flush, stall, bubble, in_valid, in_pc, in_instr, in_exc, in_bd, in_data,
    input  valid_q, pc_q, instr_q, exc_q, bd_q, data_q, rs_q, rt_q, imm16_q, index26_q,
           stall_cnt
  );

  modport slave (
    input  req, flush, stall, bubble, in_valid, in_pc, in_instr, in_exc, in_bd, in_data,
    output valid_q, pc_q, instr_q, exc_q, bd_q, data_q, rs_q, rt_q, imm16_q, index26_q,
           stall_cnt
  );
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_reg;

  // Count up on inc, stick at all-ones, clear has priority
  always_ff @(posedge clk) begin
    if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count = count_reg;
endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register of the 5-stage MIPS core. Holds one slot
// (valid, PC, instruction, exception, delay-slot flag, payload) and offers the
// rs/rt/imm16/index26 fields pre-sliced so consumers never re-slice.
module pipe_stage_reg
  import cpu_pkg::*;
#(
  parameter int          DATA_W         = 32,
  parameter int          EXC_W          = CPU_EXC_W,
  parameter logic [31:0] HANDLER_PC     = CPU_HANDLER_PC,
  parameter bit          BUBBLE_KEEP_PC = 1'b1,
  parameter bit          EXC_KILL_INSTR = 1'b1,
  parameter int          CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  pipe_stage_if.slave bus
);

  action_e act;

  logic              valid_reg, valid_next;
  logic [31:0]       pc_reg, pc_next;
  logic [31:0]       instr_reg, instr_next;
  logic [EXC_W-1:0]  exc_reg, exc_next;
  logic              bd_reg, bd_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [4:0]        rs_reg, rt_reg;
  logic [15:0]       imm16_reg;
  logic [25:0]       index26_reg;
  logic [CNT_W-1:0]  stall_cnt;
  logic              cnt_inc;

  // Pick the single action for this edge
  always_comb act = decode_action(bus.req, bus.flush, bus.stall, bus.bubble);

  // Next slot contents for the chosen action
  always_comb begin
    valid_next = valid_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    exc_next   = exc_reg;
    bd_next    = bd_reg;
    data_next  = data_reg;
    case (act)
      ACT_REQ: begin
        valid_next = 1'b0;
        pc_next    = HANDLER_PC;
        instr_next = '0;
        exc_next   = '0;
        bd_next    = 1'b0;
        data_next  = '0;
      end
      ACT_FLUSH: begin
        valid_next = 1'b0;
        pc_next    = '0;
        instr_next = '0;
        exc_next   = '0;
        bd_next    = 1'b0;
        data_next  = '0;
      end
      ACT_STALL: begin
        // hold everything
      end
      ACT_BUBBLE: begin
        // Keeping the incoming PC/bd lets an interrupt taken while the
        // bubble is in flight still report the right restart address.
        valid_next = 1'b0;
        instr_next = '0;
        exc_next   = '0;
        data_next  = '0;
        pc_next    = BUBBLE_KEEP_PC ? bus.in_pc : 32'h0;
        bd_next    = BUBBLE_KEEP_PC ? bus.in_bd : 1'b0;
      end
      default: begin
        valid_next = bus.in_valid;
        pc_next    = bus.in_pc;
        exc_next   = bus.in_exc;
        bd_next    = bus.in_bd;
        data_next  = bus.in_data;
        // A faulting instruction must not execute: turn it into a nop
        if (EXC_KILL_INSTR && (bus.in_exc != '0)) begin
          instr_next = '0;
        end else begin
          instr_next = bus.in_instr;
        end
      end
    endcase
  end

  // Slot register; the field slices are taken from instr_next so they
  // update on the same edge as instr_q
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg   <= 1'b0;
      pc_reg      <= '0;
      instr_reg   <= '0;
      exc_reg     <= '0;
      bd_reg      <= 1'b0;
      data_reg    <= '0;
      rs_reg      <= '0;
      rt_reg      <= '0;
      imm16_reg   <= '0;
      index26_reg <= '0;
    end else begin
      valid_reg   <= valid_next;
      pc_reg      <= pc_next;
      instr_reg   <= instr_next;
      exc_reg     <= exc_next;
      bd_reg      <= bd_next;
      data_reg    <= data_next;
      rs_reg      <= instr_next[RS_MSB:RS_LSB];
      rt_reg      <= instr_next[RT_MSB:RT_LSB];
      imm16_reg   <= instr_next[IMM_MSB:0];
      index26_reg <= instr_next[INDEX_MSB:0];
    end
  end

  // Only a genuine stall of a valid slot counts; req/flush win over stall
  assign cnt_inc = (act == ACT_STALL) && valid_reg;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clr  (reset),
    .inc  (cnt_inc),
    .count(stall_cnt)
  );

  assign bus.valid_q   = valid_reg;
  assign bus.pc_q      = pc_reg;
  assign bus.instr_q   = instr_reg;
  assign bus.exc_q     = exc_reg;
  assign bus.bd_q      = bd_reg;
  assign bus.data_q    = data_reg;
  assign bus.rs_q      = rs_reg;
  assign bus.rt_q      = rt_reg;
  assign bus.imm16_q   = imm16_reg;
  assign bus.index26_q = index26_reg;
  assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: two stage registers (default build, and CNT_W=2 with
// bubbles zeroing PC/bd) see identical stimulus; expected slots are queued
// when stimulus is applied and compared after the edge.
module tb_pipe_stage_reg;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, flush, stall, bubble, in_valid, in_bd;
  logic [31:0] in_pc, in_instr, in_data;
  logic [4:0]  in_exc;

  pipe_stage_if #(.DATA_W(32), .EXC_W(5), .CNT_W(16)) if_a ();
  pipe_stage_if #(.DATA_W(32), .EXC_W(5), .CNT_W(2))  if_b ();

  assign if_a.req = req;       assign if_b.req = req;
  assign if_a.flush = flush;   assign if_b.flush = flush;
  assign if_a.stall = stall;   assign if_b.stall = stall;
  assign if_a.bubble = bubble; assign if_b.bubble = bubble;
  assign if_a.in_valid = in_valid; assign if_b.in_valid = in_valid;
  assign if_a.in_pc = in_pc;       assign if_b.in_pc = in_pc;
  assign if_a.in_instr = in_instr; assign if_b.in_instr = in_instr;
  assign if_a.in_exc = in_exc;     assign if_b.in_exc = in_exc;
  assign if_a.in_bd = in_bd;       assign if_b.in_bd = in_bd;
  assign if_a.in_data = in_data;   assign if_b.in_data = in_data;

  pipe_stage_reg #(.DATA_W(32), .EXC_W(5), .HANDLER_PC(32'h0000_4180),
                   .BUBBLE_KEEP_PC(1'b1), .EXC_KILL_INSTR(1'b1), .CNT_W(16))
    dut_a (.clk(clk), .reset(rst), .bus(if_a));

  pipe_stage_reg #(.DATA_W(32), .EXC_W(5), .HANDLER_PC(32'h0000_4180),
                   .BUBBLE_KEEP_PC(1'b0), .EXC_KILL_INSTR(1'b1), .CNT_W(2))
    dut_b (.clk(clk), .reset(rst), .bus(if_b));

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        bd;
    logic [31:0] data;
    int          cnt;
  } slot_t;

  slot_t m_a, m_b;
  slot_t q_a[$];
  slot_t q_b[$];
  int n_vec  = 0;
  int n_err  = 0;
  int n_txn  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Reference behaviour of one edge for a given build
  function automatic slot_t step(input slot_t s, input bit keep_pc, input int cmax);
    slot_t n = s;
    if (rst) begin
      n = '0;
    end else if (req) begin
      n.valid = 1'b0; n.pc = 32'h0000_4180; n.instr = '0;
      n.exc = '0; n.bd = 1'b0; n.data = '0;
    end else if (flush) begin
      n.valid = 1'b0; n.pc = '0; n.instr = '0;
      n.exc = '0; n.bd = 1'b0; n.data = '0;
    end else if (stall) begin
      if (s.valid && s.cnt < cmax) n.cnt = s.cnt + 1;
    end else if (bubble) begin
      n.valid = 1'b0; n.instr = '0; n.exc = '0; n.data = '0;
      n.pc = keep_pc ? in_pc : 32'h0;
      n.bd = keep_pc ? in_bd : 1'b0;
    end else begin
      n.valid = in_valid; n.pc = in_pc; n.exc = in_exc; n.bd = in_bd; n.data = in_data;
      n.instr = (in_exc != 5'd0) ? 32'h0 : in_instr;
    end
    return n;
  endfunction

  task automatic compare_slot(input string who, input slot_t e,
                              input logic v, input logic [31:0] pc, input logic [31:0] instr,
                              input logic [4:0] exc, input logic bd, input logic [31:0] data,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic [15:0] imm, input logic [25:0] idx, input int cnt);
    check({who, ".valid_q"},   64'(v),     64'(e.valid));
    check({who, ".pc_q"},      64'(pc),    64'(e.pc));
    check({who, ".instr_q"},   64'(instr), 64'(e.instr));
    check({who, ".exc_q"},     64'(exc),   64'(e.exc));
    check({who, ".bd_q"},      64'(bd),    64'(e.bd));
    check({who, ".data_q"},    64'(data),  64'(e.data));
    check({who, ".rs_q"},      64'(rs),    64'(e.instr[25:21]));
    check({who, ".rt_q"},      64'(rt),    64'(e.instr[20:16]));
    check({who, ".imm16_q"},   64'(imm),   64'(e.instr[15:0]));
    check({who, ".index26_q"}, 64'(idx),   64'(e.instr[25:0]));
    check({who, ".stall_cnt"}, 64'(cnt),   64'(e.cnt));
  endtask

  // Drive one edge of stimulus, queue expectations, compare after the edge
  task automatic apply(input string tag, input bit r, input bit rq, input bit fl,
                       input bit st, input bit bu, input bit v, input logic [31:0] pc,
                       input logic [31:0] instr, input logic [4:0] exc, input bit bd,
                       input logic [31:0] data);
    slot_t ea, eb;
    rst = r; req = rq; flush = fl; stall = st; bubble = bu;
    in_valid = v; in_pc = pc; in_instr = instr; in_exc = exc; in_bd = bd; in_data = data;
    m_a = step(m_a, 1'b1, 65535);
    m_b = step(m_b, 1'b0, 3);
    q_a.push_back(m_a);
    q_b.push_back(m_b);
    @(posedge clk);
    #1;
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    compare_slot("a", ea, if_a.valid_q, if_a.pc_q, if_a.instr_q, if_a.exc_q, if_a.bd_q,
                 if_a.data_q, if_a.rs_q, if_a.rt_q, if_a.imm16_q, if_a.index26_q,
                 int'(if_a.stall_cnt));
    compare_slot("b", eb, if_b.valid_q, if_b.pc_q, if_b.instr_q, if_b.exc_q, if_b.bd_q,
                 if_b.data_q, if_b.rs_q, if_b.rt_q, if_b.imm16_q, if_b.index26_q,
                 int'(if_b.stall_cnt));
    n_txn++;
    $display("txn %0d %s: a v=%0b pc=%h instr=%h exc=%0d cnt=%0d | b pc=%h bd=%0b cnt=%0d",
             n_txn, tag, if_a.valid_q, if_a.pc_q, if_a.instr_q, if_a.exc_q,
             if_a.stall_cnt, if_b.pc_q, if_b.bd_q, if_b.stall_cnt);
  endtask

  initial begin
    m_a = '0; m_b = '0;
    rst = 1'b1; req = 1'b0; flush = 1'b0; stall = 1'b0; bubble = 1'b0;
    in_valid = 1'b0; in_pc = '0; in_instr = '0; in_exc = '0; in_bd = 1'b0; in_data = '0;

    // Reset with busy inputs
    apply("reset", 1, 0, 0, 0, 0, 1, 32'h1234, 32'hDEADBEEF, 5'd3, 1, 32'h55);
    check("rst_pc", 64'(if_a.pc_q), 64'h0);
    check("rst_cnt", 64'(if_a.stall_cnt), 64'h0);

    // Load lw $10,16($1)
    apply("load", 0, 0, 0, 0, 0, 1, 32'h3004, 32'h8C2A0010, EXC_NONE, 0, 32'hA5A5);
    check("ld_pc", 64'(if_a.pc_q), 64'h3004);
    check("ld_rs", 64'(if_a.rs_q), 64'd1);
    check("ld_rt", 64'(if_a.rt_q), 64'd10);
    check("ld_imm", 64'(if_a.imm16_q), 64'h10);
    check("ld_valid", 64'(if_a.valid_q), 64'd1);

    // Stall with changing inputs: contents hold, counters run
    for (int i = 0; i < 3; i++)
      apply("stall", 0, 0, 0, 1, 0, 1, 32'h9000 + i, $urandom, 5'd0, 1, $urandom);
    check("stall3_a", 64'(if_a.stall_cnt), 64'd3);
    check("stall3_pc", 64'(if_a.pc_q), 64'h3004);
    for (int i = 0; i < 2; i++)
      apply("stall", 0, 0, 0, 1, 0, 1, 32'h9100 + i, $urandom, 5'd0, 0, $urandom);
    check("stall5_a", 64'(if_a.stall_cnt), 64'd5);
    check("sat_b", 64'(if_b.stall_cnt), 64'd3);

    // Exception request beats stall
    apply("req+stall", 0, 1, 0, 1, 0, 1, 32'h3008, 32'h12345678, 5'd0, 0, 32'h1);
    check("req_pc", 64'(if_a.pc_q), 64'h4180);
    check("req_instr", 64'(if_a.instr_q), 64'h0);
    check("req_valid", 64'(if_a.valid_q), 64'd0);
    apply("stall-idle", 0, 0, 0, 1, 0, 1, 32'h300C, 32'h1, 5'd0, 0, 32'h2);

    // Bubble: build a keeps PC/bd, build b zeroes them
    apply("bubble", 0, 0, 0, 0, 1, 1, 32'h300C, 32'h24420001, 5'd0, 1, 32'h3);
    check("bub_pc_a", 64'(if_a.pc_q), 64'h300C);
    check("bub_bd_a", 64'(if_a.bd_q), 64'd1);
    check("bub_pc_b", 64'(if_b.pc_q), 64'h0);
    check("bub_bd_b", 64'(if_b.bd_q), 64'd0);

    // Faulting fetch becomes a nop, then a flush empties the slot
    apply("load-exc", 0, 0, 0, 0, 0, 1, 32'h3010, 32'hFFFFFFFF, EXC_ADEL, 1, 32'h4);
    check("exc_instr", 64'(if_a.instr_q), 64'h0);
    check("exc_code", 64'(if_a.exc_q), 64'd4);
    check("exc_pc", 64'(if_a.pc_q), 64'h3010);
    apply("flush", 0, 0, 1, 1, 0, 1, 32'h3014, 32'h8C2A0010, 5'd0, 1, 32'h5);
    check("fl_pc", 64'(if_a.pc_q), 64'h0);
    check("fl_exc", 64'(if_a.exc_q), 64'h0);

    // Reset in the middle of a stall clears the counter
    apply("load", 0, 0, 0, 0, 0, 1, 32'h3018, 32'h00851020, 5'd0, 0, 32'h6);
    apply("stall", 0, 0, 0, 1, 0, 1, 32'h301C, 32'h0, 5'd0, 0, 32'h7);
    apply("rst+stall", 1, 0, 0, 1, 0, 1, 32'h301C, 32'h0, 5'd0, 0, 32'h7);
    check("rst_mid_cnt", 64'(if_a.stall_cnt), 64'd0);

    // Random mix of actions
    for (int i = 0; i < 200; i++) begin
      apply("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0), 1'($urandom), {$urandom_range(0, 16'hFFFF), 2'b00},
            $urandom, ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
            1'($urandom), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
